// File: rtl/fib_pkg.sv
// fib_pkg -- shared definitions for the Fibonacci sequencer slice.
//
// Contents:
//   CNT_W_DEFAULT : default width of the iteration count / step counter
//   fib_state_t   : binary-encoded control state (IDLE=0, INIT=1, STEP=2, DONE=3)
package fib_pkg;

  localparam int CNT_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    STEP = 2'd2,
    DONE = 2'd3
  } fib_state_t;

endpackage

// File: rtl/fib_step_counter.sv
// fib_step_counter -- holds the latched iteration count and counts issued steps.
//
// Ports:
//   clk    in   rising-edge clock
//   clr    in   synchronous active-high reset; clears count and n_q
//   load   in   start of a run: latch n into n_q and clear count
//   en     in   a step is issued this cycle; count increments on the edge
//   n      in   CNT_W  requested number of steps
//   count  out  CNT_W  steps completed in the current or last run
//   last   out  the step issued this cycle is the final one (count+1 == n_q)
//   n_zero out  the latched run has no steps at all
module fib_step_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] n,
  output logic [CNT_W-1:0] count,
  output logic             last,
  output logic             n_zero
);

  logic [CNT_W-1:0] n_q;

  // Load takes priority over enable; the FSM never asserts both together.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
      n_q   <= '0;
    end else if (load) begin
      count <= '0;
      n_q   <= n;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  // Compare one bit wider so count+1 cannot alias back to zero when n_q is
  // all-ones.
  assign last   = ({1'b0, count} + {{CNT_W{1'b0}}, 1'b1}) == {1'b0, n_q};
  assign n_zero = (n_q == '0);

endmodule

// File: rtl/fib_sequencer.sv
// fib_sequencer -- control FSM that sequences the Fibonacci datapath.
// A start request latches n, pulses dp_init (A=0, B=1), issues exactly n
// dp_step strobes (A<-B, B<-A+B) and then pulses done.
//
// Ports:
//   clk     in   rising-edge clock
//   CLR     in   synchronous active-high reset
//   start   in   run request, accepted only while idle
//   n       in   CNT_W  number of steps, latched on acceptance
//   ovf     in   datapath adder overflow, meaningful during step cycles
//   dp_init out  one-cycle datapath load strobe
//   dp_step out  datapath step enable
//   busy    out  high from the init cycle through the done cycle
//   done    out  one-cycle completion pulse
//   err     out  run was aborted by overflow (stays until next start/CLR)
//   count   out  CNT_W  steps completed in the current or last run
//
// Build option: define FIB_OVF_ABORT_EN to abort a run when ovf is seen in a
// step cycle. Without it ovf is ignored and err is tied low.
module fib_sequencer
  import fib_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic             start,
  input  logic [CNT_W-1:0] n,
  input  logic             ovf,
  output logic             dp_init,
  output logic             dp_step,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] count
);

  fib_state_t state_q, state_d;
  logic accept;
  logic step_en;
  logic last_step;
  logic n_zero;
  logic abort;

  assign accept  = (state_q == IDLE) && start;
  assign step_en = (state_q == STEP);

  fib_step_counter #(.CNT_W(CNT_W)) u_counter (
    .clk    (clk),
    .clr    (CLR),
    .load   (accept),
    .en     (step_en),
    .n      (n),
    .count  (count),
    .last   (last_step),
    .n_zero (n_zero)
  );

`ifdef FIB_OVF_ABORT_EN
  // The overflowing step has already been issued, so the run ends right
  // after it and err marks the result as invalid.
  assign abort = step_en && ovf;

  always_ff @(posedge clk) begin
    if (CLR) begin
      err <= 1'b0;
    end else if (accept) begin
      err <= 1'b0;
    end else if (abort) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_ovf;
  assign unused_ovf = ovf;
  assign abort      = 1'b0;
  assign err        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (CLR) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are a pure decode of the registered state, so dp_init and
  // dp_step can never overlap.
  always_comb begin
    state_d = state_q;
    dp_init = 1'b0;
    dp_step = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = INIT;
      end
      INIT: begin
        dp_init = 1'b1;
        busy    = 1'b1;
        state_d = n_zero ? DONE : STEP;
      end
      STEP: begin
        dp_step = 1'b1;
        busy    = 1'b1;
        if (abort || last_step) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        busy    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fib_sequencer.sv
// tb_fib_sequencer -- self-checking bench for fib_sequencer.
// A timeline model predicts every output from the cycle offset since the
// accepted start; directed runs pin that model with literal values, then a
// randomized phase exercises start/n/ovf/CLR combinations.
module tb_fib_sequencer;
  import fib_pkg::*;

  localparam int CNT_W = CNT_W_DEFAULT;
  localparam int MAXN  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             CLR;
  logic             start;
  logic [CNT_W-1:0] n;
  logic             ovf;
  logic             dp_init, dp_step, busy, done, err;
  logic [CNT_W-1:0] count;

  int testsRun    = 0;
  int testsFailed = 0;

  fib_sequencer #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .CLR     (CLR),
    .start   (start),
    .n       (n),
    .ovf     (ovf),
    .dp_init (dp_init),
    .dp_step (dp_step),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .count   (count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Inputs change only on the falling edge.
  task automatic applyStimulus(input logic s, input logic [CNT_W-1:0] nv,
                               input logic o, input logic c);
    start = s;
    n     = nv;
    ovf   = o;
    CLR   = c;
  endtask

  // Datapath the sequencer would be driving: A and B operand registers.
  logic [15:0] fibA, fibB;
  always @(posedge clk) begin
    if (dp_init) begin
      fibA <= 16'd0;
      fibB <= 16'd1;
    end else if (dp_step) begin
      fibA <= fibB;
      fibB <= fibA + fibB;
    end
  end

  // Timeline model: a run accepted at edge runT0 has INIT at offset 1,
  // steps at offsets 2..runEnd-1 and DONE at offset runEnd.
  int edgeIdx  = 0;
  bit active   = 0;
  int runT0    = 0;
  int runEnd   = 0;
  int expCount = 0;
  bit expErr   = 0;

  always @(posedge clk) begin : model
    int k;
    edgeIdx++;
    if (CLR) begin
      active   = 0;
      expCount = 0;
      expErr   = 0;
    end else if (active) begin
      k = edgeIdx - runT0;
      if (k >= 2 && k < runEnd) begin
        expCount++;
`ifdef FIB_OVF_ABORT_EN
        if (ovf) begin
          runEnd = k + 1;
          expErr = 1;
        end
`endif
      end else if (k == runEnd) begin
        active = 0;
      end
    end else if (start) begin
      active   = 1;
      runT0    = edgeIdx;
      runEnd   = int'(n) + 2;
      expCount = 0;
      expErr   = 0;
    end
  end

  always @(negedge clk) begin : compare
    int k;
    if (edgeIdx > 0) begin
      k = edgeIdx - runT0 + 1;
      checkOutput("dp_init", dp_init, active && k == 1);
      checkOutput("dp_step", dp_step, active && k >= 2 && k < runEnd);
      checkOutput("done",    done,    active && k == runEnd);
      checkOutput("busy",    busy,    active);
      checkOutput("err",     err,     expErr);
      checkOutput("count",   count,   expCount);
    end
  end

  // One directed run with hand-computed expectations; entered and left on a
  // falling edge with the sequencer idle.
  task automatic runDirected(input string tag, input int nVal, input int expSteps,
                             input int expLat, input int expA, input int expB);
    int steps;
    int lat;
    applyStimulus(1'b1, CNT_W'(nVal), 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, CNT_W'($urandom_range(0, MAXN)), 1'b0, 1'b0);
    checkOutput({tag, "_init"}, dp_init, 1);
    steps = 0;
    lat   = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (dp_step) steps++;
    end
    checkOutput({tag, "_done_seen"}, done, 1);
    checkOutput({tag, "_steps"}, steps, expSteps);
    checkOutput({tag, "_latency"}, lat, expLat);
    checkOutput({tag, "_count"}, count, expSteps);
    checkOutput({tag, "_A"}, fibA, expA);
    checkOutput({tag, "_B"}, fibB, expB);
    @(negedge clk);
  endtask

  initial begin : stimulus
    int steps;
    int lat;
    int gap;
    bit sawDone;

    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_count", count, 0);
    checkOutput("reset_err", err, 0);
    checkOutput("reset_done", done, 0);
    @(negedge clk);

    // n=5: init at t+1, steps t+2..t+6, done at t+7, F5=5, F6=8.
    runDirected("n5", 5, 5, 7, 5, 8);
    runDirected("n0", 0, 0, 2, 0, 1);
    runDirected("n15", 15, 15, 17, 610, 987);

    // A second start during STEP must not disturb the run.
    applyStimulus(1'b1, CNT_W'(6), 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, CNT_W'(6), 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, CNT_W'(2), 1'b0, 1'b0);
    steps = dp_step ? 1 : 0;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      applyStimulus(1'b0, CNT_W'(2), 1'b0, 1'b0);
      lat++;
      if (dp_step) steps++;
    end
    checkOutput("ignore_steps", steps, 6);
    checkOutput("ignore_count", count, 6);
    @(negedge clk);

    // Holding start high: done, one idle cycle, then the next dp_init.
    applyStimulus(1'b1, CNT_W'(3), 1'b0, 1'b0);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!dp_init && gap < 10);
    checkOutput("holdstart_gap", gap, 2);
    applyStimulus(1'b0, CNT_W'(3), 1'b0, 1'b0);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    @(negedge clk);

    // CLR in the third step cycle aborts silently.
    applyStimulus(1'b1, CNT_W'(8), 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, CNT_W'(8), 1'b0, 1'b0);
    steps = 0;
    lat = 0;
    while (steps < 3 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (dp_step) steps++;
    end
    applyStimulus(1'b0, CNT_W'(8), 1'b0, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, CNT_W'(8), 1'b0, 1'b0);
    checkOutput("clr_busy", busy, 0);
    checkOutput("clr_count", count, 0);
    checkOutput("clr_step", dp_step, 0);
    sawDone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || dp_step) sawDone = 1;
    end
    checkOutput("clr_no_done", sawDone, 0);

    // Overflow raised during the 4th step of a 15-step run.
    applyStimulus(1'b1, CNT_W'(15), 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, CNT_W'(15), 1'b0, 1'b0);
    steps = 0;
    lat = 0;
    while (steps < 4 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (dp_step) steps++;
    end
    applyStimulus(1'b0, CNT_W'(15), 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, CNT_W'(15), 1'b0, 1'b0);
`ifdef FIB_OVF_ABORT_EN
    checkOutput("ovf_done", done, 1);
    checkOutput("ovf_err", err, 1);
    checkOutput("ovf_count", count, 4);
`else
    lat = 0;
    while (!done && lat < 40) begin
      if (dp_step) steps++;
      @(negedge clk);
      lat++;
    end
    checkOutput("ovf_ignored_steps", steps, 15);
    checkOutput("ovf_ignored_err", err, 0);
    checkOutput("ovf_ignored_count", count, 15);
`endif
    @(negedge clk);

    // Randomized traffic, checked every cycle by the compare process.
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 3) == 0, CNT_W'($urandom_range(0, MAXN)),
                    $urandom_range(0, 9) == 0, $urandom_range(0, 59) == 0);
      @(negedge clk);
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    repeat (25) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/fib_sequencer.md
# fib_sequencer

Control FSM that sequences the Fibonacci datapath. The datapath is built from registered select cells and holds two operand registers, A and B. On a start request, the block latches an iteration count and pulses an init strobe that loads A=0 and B=1. It then issues exactly N step strobes, each performing A←B and B←A+B, and pulses `done`. It sits between the board-level start/count inputs and the datapath's load/enable controls, and is the only driver of those controls.

## Interface
- CNT_W, 4, width of the iteration count and step counter (N ranges 0..2^CNT_W−1)

- clk  input  1  rising-edge clock, the only clock
- CLR  input  1  reset; synchronous and active-high, sampled on the rising edge of clk
- start  input  1  level-sampled request; accepted only in IDLE
- n  input  CNT_W  number of step cycles; latched when start is accepted
- ovf  input  1  datapath adder overflow flag, valid during STEP cycles
- dp_init  output  1  one-cycle strobe; datapath loads A=0, B=1
- dp_step  output  1  step enable; datapath performs A←B, B←A+B on that edge
- busy  output  1  high in INIT, STEP and DONE
- done  output  1  one-cycle completion pulse
- err  output  1  high with done when the run was aborted by overflow
- count  output  CNT_W  steps completed in the current or last run

## Operation
- States: IDLE, INIT, STEP, DONE. Binary-encoded state register.
- IDLE: if start=1 → INIT; latch n into n_q; clear count.
- INIT: dp_init=1.
  - n_q=0 → DONE (result F0=0, no step issued).
  - Otherwise → STEP.
- STEP: dp_step=1; count increments on each STEP edge.
  - When count+1 == n_q → DONE.
  - Otherwise stay in STEP.
- DONE: done=1 for exactly one cycle → IDLE. count holds its value until the next accepted start.
- Outputs are a Moore decode of the registered state. dp_init and dp_step are never high in the same cycle.
- start outside IDLE is ignored; there is no queueing. Holding start high produces back-to-back runs with one IDLE cycle between them.
- n changes after acceptance have no effect.
- count never wraps: the maximum is 2^CNT_W−1 steps, reached when n is all-ones.

## Timing
- Reset: the CLR edge forces IDLE and sets count=0, n_q=0, err=0. All outputs are 0 the cycle after reset.
- CLR mid-run aborts on that edge: no done pulse and no further dp_step. CLR takes priority over start on the same edge.
- With start sampled high in IDLE at edge t:
  - INIT during cycle t+1.
  - STEP during cycles t+2 .. t+1+n.
  - DONE during cycle t+2+n.
  - IDLE at t+3+n.
- With n=0: INIT at t+1, DONE at t+2.
- busy rises one cycle after start is accepted and falls in the same cycle done falls.

## Configuration
- FIB_OVF_ABORT_EN defined:
  - ovf=1 in a STEP cycle forces the next state to DONE with err=1. That step's dp_step has already been issued.
  - count reflects the steps issued, including the overflowing one.
  - err clears on the next accepted start or on CLR.
- FIB_OVF_ABORT_EN undefined: ovf is ignored and err is constant 0. The port list is identical in both builds.

## Structure
- Package fib_pkg holds:
  - the state enum/localparams (IDLE=0, INIT=1, STEP=2, DONE=3);
  - the default CNT_W.
- One sub-module, fib_step_counter:
  - loadable CNT_W-bit counter with clear, enable and a terminal-match output (count+1 == n_q).
  - FSM logic stays in fib_sequencer.

## Test plan
- CLR held 3 cycles, then released → state IDLE; dp_init, dp_step, busy, done, err and count all 0.
- start pulse with n=5 at edge t → dp_init at t+1; dp_step t+2..t+6; done at t+7; count=5; datapath B=8.
- n=0 → dp_init at t+1, done at t+2, no dp_step; n=15 (CNT_W=4) → 15 steps, count=15, no wrap.
- Second start asserted during STEP is ignored; holding start high gives runs separated by exactly 1 IDLE cycle.
- CLR asserted in the third STEP cycle → IDLE next edge, no done, count=0.
- With FIB_OVF_ABORT_EN, n=15, ovf forced at the 4th step → done and err high one cycle later, count=4. Without the macro → full 15 steps, err=0.
